// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer that drives the PC register's load/increment controls.
// Optional interrupt entry is enabled by defining PC_SEQUENCER_IRQ_EN.
module pc_sequencer #(
  parameter int unsigned   n         = 32,
  parameter logic [n-1:0]  RESET_VEC = '0,
  parameter int unsigned   TIMEOUT   = 16,
  parameter logic [n-1:0]  IRQ_VEC   = n'(32'h100)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] pc_cur,
  output logic         PCload,
  output logic         PCinc,
  output logic [n-1:0] PCdata,
  output logic         fetch_valid,
  input  logic         fetch_ready,
  input  logic         exec_done,
  input  logic         br_taken,
  input  logic [n-1:0] br_target,
  input  logic         halt_req,
`ifdef PC_SEQUENCER_IRQ_EN
  input  logic         irq,
  output logic         irq_ack,
  output logic [n-1:0] epc,
`endif
  output logic         busy,
  output logic         halted,
  output logic         err,
  output logic [n-1:0] retired
);

  localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TONE  = TW'(1);
  localparam logic [n-1:0]  ONE   = n'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_ERROR} state_t;

  state_t        state, nstate;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          ret_inc;

`ifdef PC_SEQUENCER_IRQ_EN
  logic [n-1:0]  epc_nxt;
  logic          irq_take;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      retired <= '0;
      tcnt    <= '0;
`ifdef PC_SEQUENCER_IRQ_EN
      epc     <= '0;
`endif
    end else begin
      state <= nstate;
      tcnt  <= tcnt_nxt;
      if (ret_inc) retired <= retired + ONE;
`ifdef PC_SEQUENCER_IRQ_EN
      if (irq_take) epc <= epc_nxt;
`endif
    end
  end

  // Mealy PC controls are suppressed while rst is high so reset wins outright.
  always_comb begin
    nstate      = state;
    tcnt_nxt    = '0;
    ret_inc     = 1'b0;
    PCload      = 1'b0;
    PCinc       = 1'b0;
    PCdata      = '0;
    fetch_valid = 1'b0;
`ifdef PC_SEQUENCER_IRQ_EN
    irq_ack     = 1'b0;
    irq_take    = 1'b0;
    epc_nxt     = br_taken ? br_target : pc_cur + ONE;
`endif
    if (!rst) begin
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            PCload = 1'b1;
            PCdata = RESET_VEC;
            nstate = S_FETCH;
          end
        end
        S_FETCH: begin
          fetch_valid = 1'b1;
          if (fetch_ready)        nstate = S_EXEC;
          else if (tcnt == TLAST) nstate = S_ERROR;
          else                    tcnt_nxt = tcnt + TONE;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt_req) begin
              nstate = S_HALT;
            end
`ifdef PC_SEQUENCER_IRQ_EN
            else if (irq) begin
              PCload   = 1'b1;
              PCdata   = IRQ_VEC;
              irq_ack  = 1'b1;
              irq_take = 1'b1;
              ret_inc  = 1'b1;
              nstate   = S_FETCH;
            end
`endif
            else if (br_taken) begin
              PCload  = 1'b1;
              PCdata  = br_target;
              ret_inc = 1'b1;
              nstate  = S_FETCH;
            end else begin
              PCinc   = 1'b1;
              ret_inc = 1'b1;
              nstate  = S_FETCH;
            end
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_FETCH) || (state == S_EXEC);
  assign halted = (state == S_HALT);
  assign err    = (state == S_ERROR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a bench-side PC register closes the loop on pc_cur.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, fetch_ready, exec_done, br_taken, halt_req;
  logic [31:0] br_target;
  logic        PCload, PCinc, fetch_valid, busy, halted, err;
  logic [31:0] PCdata, retired, pc_cur;
  logic [31:0] pc = 32'h0000_dead;
`ifdef PC_SEQUENCER_IRQ_EN
  logic        irq, irq_ack;
  logic [31:0] epc;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (PCload)     pc <= PCdata;
    else if (PCinc) pc <= pc + 32'd1;
  assign pc_cur = pc;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pc_cur(pc_cur),
    .PCload(PCload), .PCinc(PCinc), .PCdata(PCdata),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req),
`ifdef PC_SEQUENCER_IRQ_EN
    .irq(irq), .irq_ack(irq_ack), .epc(epc),
`endif
    .busy(busy), .halted(halted), .err(err), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    start = 0; fetch_ready = 0; exec_done = 0; br_taken = 0; halt_req = 0; br_target = '0;
`ifdef PC_SEQUENCER_IRQ_EN
    irq = 0;
`endif
  endtask

  // One FETCH cycle accepted immediately at the expected address.
  task automatic fetch_ok(input logic [31:0] addr);
    @(negedge clk); idle_in(); fetch_ready = 1;
    #1 chk("fetch_valid", {31'd0, fetch_valid}, 1);
    chk("fetch_addr", pc_cur, addr);
  endtask

  task automatic exec_inc();
    @(negedge clk); idle_in(); exec_done = 1;
    #1 chk("inc_PCinc", {31'd0, PCinc}, 1);
    chk("inc_PCload", {31'd0, PCload}, 0);
  endtask

  task automatic restart();
    @(negedge clk); idle_in(); start = 1;
    #1 chk("start_PCload", {31'd0, PCload}, 1);
    chk("start_PCdata", PCdata, 0);
  endtask

  initial begin
    idle_in(); rst = 1;
    @(negedge clk); @(negedge clk);
    #1 chk("rst_PCload", {31'd0, PCload}, 0);
    chk("rst_PCinc", {31'd0, PCinc}, 0);
    chk("rst_PCdata", PCdata, 0);
    chk("rst_fv", {31'd0, fetch_valid}, 0);
    chk("rst_flags", {29'd0, busy, halted, err}, 0);
    chk("rst_retired", retired, 0);

    // Start and three sequential instructions
    rst = 0;
    restart();
    for (int i = 0; i < 3; i++) begin fetch_ok(i); exec_inc(); end
    @(negedge clk); idle_in();
    #1 chk("seq_pc", pc_cur, 3);
    chk("seq_retired", retired, 3);

    // Branch taken at pc 5
    exec_done = 0; fetch_ready = 1;
    @(negedge clk); idle_in(); exec_done = 1; // EXEC at pc 3
    #1 chk("pc3_inc", {31'd0, PCinc}, 1);
    fetch_ok(4); exec_inc();
    fetch_ok(5);
    @(negedge clk); idle_in(); exec_done = 1; br_taken = 1; br_target = 32'h40;
    #1 chk("br_PCload", {31'd0, PCload}, 1);
    chk("br_PCdata", PCdata, 32'h40);
    chk("br_PCinc", {31'd0, PCinc}, 0);

    // Fetch stall: 5 cycles not ready, then accepted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_in();
      #1 chk("stall_fv", {31'd0, fetch_valid}, 1);
      chk("stall_pc", {PCload, PCinc, pc_cur[29:0]}, 32'h40);
    end
    fetch_ok(32'h40);
    @(negedge clk); idle_in(); br_taken = 1; br_target = 32'h77;
    #1 chk("exec_wait_fv", {31'd0, fetch_valid}, 0);
    chk("exec_wait_ctl", {30'd0, PCload, PCinc}, 0);
    chk("exec_busy", {31'd0, busy}, 1);
    exec_inc();
    @(negedge clk); idle_in();
    #1 chk("stall_retired", retired, 7);
    chk("post_pc", pc_cur, 32'h41);

    // Timeout: this FETCH plus 15 more not-ready cycles
    for (int i = 1; i < 16; i++) begin
      @(negedge clk); idle_in();
      #1 chk("to_fv", {31'd0, fetch_valid}, 1);
    end
    @(negedge clk); idle_in();
    #1 chk("to_err", {31'd0, err}, 1);
    chk("to_busy", {31'd0, busy}, 0);
    chk("to_fv_off", {31'd0, fetch_valid}, 0);
    restart();
    fetch_ok(0);
    chk("restart_err", {31'd0, err}, 0);
    chk("restart_retired", retired, 7);

    // Walk to pc 7 and halt with a branch also pending
    exec_inc();
    for (int i = 1; i < 7; i++) begin fetch_ok(i); exec_inc(); end
    fetch_ok(7);
    @(negedge clk); idle_in(); exec_done = 1; halt_req = 1; br_taken = 1; br_target = 32'h55;
    #1 chk("halt_ctl", {30'd0, PCload, PCinc}, 0);
    @(negedge clk); idle_in();
    #1 chk("halted", {31'd0, halted}, 1);
    chk("halt_busy", {31'd0, busy}, 0);
    chk("halt_retired", retired, 14);
    chk("halt_pc", pc_cur, 7);
    restart();
    fetch_ok(0);
    chk("unhalt", {31'd0, halted}, 0);

`ifdef PC_SEQUENCER_IRQ_EN
    exec_inc();
    for (int i = 1; i < 9; i++) begin fetch_ok(i); exec_inc(); end
    fetch_ok(9);
    @(negedge clk); idle_in(); exec_done = 1; irq = 1;
    #1 chk("irq_PCload", {31'd0, PCload}, 1);
    chk("irq_PCdata", PCdata, 32'h100);
    chk("irq_ack", {31'd0, irq_ack}, 1);
    fetch_ok(32'h100);
    chk("irq_epc", epc, 10);
`endif

    // Reset while in FETCH
    rst = 1;
    #1 chk("rstF_fv", {31'd0, fetch_valid}, 0);
    @(negedge clk); rst = 0; idle_in();
    #1 chk("rstF_busy", {31'd0, busy}, 0);
    chk("rstF_retired", retired, 0);
    chk("rstF_fv_after", {31'd0, fetch_valid}, 0);

    // Reset while in EXEC with exec_done pending
    restart();
    fetch_ok(0);
    @(negedge clk); idle_in(); exec_done = 1; rst = 1;
    #1 chk("rstE_ctl", {30'd0, PCload, PCinc}, 0);
    @(negedge clk); rst = 0; idle_in();
    #1 chk("rstE_flags", {29'd0, busy, halted, err}, 0);
    chk("rstE_retired", retired, 0);
    chk("rstE_pc", pc_cur, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute sequencer for the program counter register (PCout/PCload/PCinc/PCdata interface).
- Starts execution at a reset vector and issues instruction-fetch handshakes.
- After each executed instruction, drives exactly one PC update: increment, branch load or vector load.
- Also handles halt, fetch timeout and retired-instruction counting; sits between the PC register, instruction memory and the execute stage.

Parameters:
- n, 32, PC / data width; must match the PC register width.
- RESET_VEC, 0, PC value loaded on start.
- TIMEOUT, 16, max FETCH cycles without fetch_ready before error; must be >= 1.
- IRQ_VEC, 32'h100, interrupt vector; used only with IRQ_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin or restart execution; honoured in IDLE, HALT and ERROR only.
- pc_cur  in  n  current PC, from the PC register output.
- PCload  out  1  load PCdata into the PC.
- PCinc  out  1  increment the PC.
- PCdata  out  n  load value for the PC.
- fetch_valid  out  1  fetch request; the address is pc_cur.
- fetch_ready  in  1  instruction memory accepts the fetch.
- exec_done  in  1  execute stage finished the current instruction; single-cycle pulse.
- br_taken  in  1  qualified by exec_done; branch taken.
- br_target  in  n  qualified by exec_done; branch destination.
- halt_req  in  1  qualified by exec_done; stop after this instruction.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.
- retired  out  n  count of completed non-halt instructions.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, retired=0, timeout counter=0.
  - All outputs 0: PCload=0, PCinc=0, PCdata=0, fetch_valid=0, busy=0, halted=0, err=0.
  - rst has priority over every other input.
- State flags (busy/halted/err) are Moore, decoded from state.
- PC controls (PCload/PCinc/PCdata) are Mealy, so the PC updates on the same edge as the state transition.
- PCload and PCinc are never both 1.
- PCdata=0 whenever PCload=0.
- States: IDLE, FETCH, EXEC, HALT, ERROR.
- IDLE:
  - start=1: PCload=1, PCdata=RESET_VEC; go to FETCH.
  - Otherwise stay.
- FETCH:
  - fetch_valid=1.
  - fetch_ready=1: handshake completes this cycle; go to EXEC; timeout counter cleared.
  - fetch_ready=0: timeout counter increments. When the counter reaches TIMEOUT-1 with fetch_ready still 0, go to ERROR at the next edge.
  - The fetch is never withdrawn once fetch_valid is raised.
  - start is ignored.
- EXEC:
  - fetch_valid=0; waits indefinitely for exec_done.
  - On exec_done, priority is halt_req > br_taken > increment:
    - halt_req: no PC update; go to HALT; retired unchanged.
    - br_taken: PCload=1, PCdata=br_target; go to FETCH; retired+1.
    - Otherwise: PCinc=1; go to FETCH; retired+1.
  - br_taken, br_target and halt_req are ignored when exec_done=0.
  - start is ignored.
- HALT and ERROR:
  - The PC is frozen.
  - start=1: PCload=1, PCdata=RESET_VEC; go to FETCH; err clears. retired is not cleared, only rst clears it.
- Arithmetic and wrap-around:
  - retired wraps from 2^n-1 to 0.
  - The PC increment wraps inside the PC register; the sequencer does no range checks.
- Minimum throughput: 2 cycles per instruction (FETCH accepted in 1 cycle, exec_done on the first EXEC cycle).
- Mid-operation reset (rst in any state): return to IDLE next edge; any in-flight fetch is abandoned with fetch_valid=0.

Optional Feature:
- Macro: PC_SEQUENCER_IRQ_EN.
- Defined:
  - Adds ports: irq (in, 1, level), irq_ack (out, 1, pulse), epc (out, n, reset 0).
  - In EXEC, on exec_done with halt_req=0 and irq=1:
    - PCload=1, PCdata=IRQ_VEC.
    - epc is set to the return PC: br_target if br_taken, else pc_cur+1.
    - irq_ack=1 for that cycle; retired+1; go to FETCH.
  - Priority: halt_req > irq > br_taken > increment.
  - irq is ignored outside exec_done.
- Not defined: the irq, irq_ack and epc ports and their logic are absent; behaviour is exactly as above.

Test Plan:
- Reset then start, RESET_VEC=0, fetch_ready=1 and exec_done every EXEC cycle, 3 instructions:
  - PCload=1 with PCdata=0 in the IDLE cycle, then PCinc=1 three times.
  - PC sequence 0,1,2,3; retired=3.
- Branch: at pc_cur=5, exec_done=1, br_taken=1, br_target=32'h40:
  - PCload=1, PCdata=32'h40, PCinc=0; next fetch at 0x40.
- Fetch stall: fetch_ready=0 for 5 cycles, then 1 (TIMEOUT=16):
  - fetch_valid held high for 6 cycles, no PC change, then EXEC.
- Timeout: fetch_ready=0 for 16 cycles:
  - err=1, busy=0.
  - start afterwards: PCload with RESET_VEC, err=0, FETCH.
- Halt: exec_done=1, halt_req=1, br_taken=1 at pc_cur=7:
  - No PCload/PCinc; halted=1; retired unchanged.
  - A start in the HALT state restarts at RESET_VEC.
- Reset in EXEC and in FETCH: next cycle state=IDLE, all outputs 0, retired=0.
- With PC_SEQUENCER_IRQ_EN: exec_done=1, irq=1, br_taken=0, pc_cur=9:
  - PCdata=32'h100, PCload=1, epc=10, irq_ack=1.
